// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and types for the write-back bypass buffer.
// Also holds the helper that encodes a candidate index as a hit level.
package pipeline_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;
    localparam logic [3:0]  HIT_NONE   = 4'hF;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } bypassEntry_t;

    // Candidate 0 is the live WB write, candidate k is buffer entry k-1.
    function automatic logic [3:0] hitLevel(input int unsigned cand);
        return cand[3:0];
    endfunction

endpackage

// File: rtl/wb_bypass_buffer_if.sv
// Write-back and ID read-port bundle for the bypass buffer.
// The pipeline drives the master side; the buffer is the slave.
interface wb_bypass_buffer_if import pipeline_pkg::*; #(
    parameter int unsigned DATA_W = REG_DATA_W,
    parameter int unsigned ADDR_W = REG_ADDR_W,
    parameter int unsigned NUM_RD = 2
);

    logic                     RegWrite_wb;
    logic [ADDR_W-1:0]        RegWriteAddr_wb;
    logic [DATA_W-1:0]        RegWriteData_wb;
    logic                     flush;
    logic [NUM_RD*ADDR_W-1:0] RdAddr_id;
    logic [NUM_RD*DATA_W-1:0] RfData_id;
    logic [NUM_RD*DATA_W-1:0] RdData_id;
    logic [NUM_RD-1:0]        Fwd_sel;
    logic [NUM_RD*4-1:0]      Fwd_hit_lvl;

    modport master (
        output RegWrite_wb, RegWriteAddr_wb, RegWriteData_wb, flush, RdAddr_id, RfData_id,
        input  RdData_id, Fwd_sel, Fwd_hit_lvl
    );

    modport slave (
        input  RegWrite_wb, RegWriteAddr_wb, RegWriteData_wb, flush, RdAddr_id, RfData_id,
        output RdData_id, Fwd_sel, Fwd_hit_lvl
    );

endinterface

// File: rtl/bypass_match.sv
// One ID read port: priority compare over the live WB write and DEPTH buffered entries.
// Lowest-numbered valid matching candidate wins, so the newest data is selected.
module bypass_match import pipeline_pkg::*; #(
    parameter int unsigned DATA_W = REG_DATA_W,
    parameter int unsigned ADDR_W = REG_ADDR_W,
    parameter int unsigned DEPTH  = 2
) (
    input  logic [ADDR_W-1:0]             rdAddr,
    input  logic [DATA_W-1:0]             rfData,
    input  logic [DEPTH:0]                candValid,
    input  logic [(DEPTH+1)*ADDR_W-1:0]   candAddr,
    input  logic [(DEPTH+1)*DATA_W-1:0]   candData,
    output logic [DATA_W-1:0]             rdData,
    output logic                          fwdSel,
    output logic [3:0]                    hitLvl
);

    always_comb begin
        rdData = rfData;
        fwdSel = 1'b0;
        hitLvl = HIT_NONE;
        // Scan oldest to newest so the last assignment is the highest-priority hit.
        for (int k = int'(DEPTH); k >= 0; k--) begin
            if (candValid[k] && (rdAddr != '0) && (candAddr[k*ADDR_W +: ADDR_W] == rdAddr)) begin
                rdData = candData[k*DATA_W +: DATA_W];
                fwdSel = 1'b1;
                hitLvl = hitLevel(unsigned'(k));
            end
        end
    end

endmodule

// File: rtl/wb_bypass_buffer.sv
// Forwards recent write-backs to ID reads until the register file has absorbed them.
// Entry 0 is the newest; the buffer shifts every cycle regardless of pipeline flow.
module wb_bypass_buffer import pipeline_pkg::*; #(
    parameter int unsigned DATA_W   = REG_DATA_W,
    parameter int unsigned ADDR_W   = REG_ADDR_W,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned DEPTH    = 2,
    parameter bit          FWD_LIVE = 1'b1
) (
    input logic               clk,
    input logic               rst,
    wb_bypass_buffer_if.slave bus
);

    if (DEPTH < 1 || DEPTH > 8) begin : gen_depth_check
        $error("wb_bypass_buffer: DEPTH must be in 1..8");
    end

    logic [DEPTH-1:0]  validQ;
    logic [ADDR_W-1:0] addrQ [DEPTH];
    logic [DATA_W-1:0] dataQ [DEPTH];

    logic liveWrite;
    assign liveWrite = bus.RegWrite_wb && (bus.RegWriteAddr_wb != '0);

    // A flush in the same cycle as a live write drops that write.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            validQ <= '0;
        end else begin
            validQ[0] <= liveWrite;
            for (int k = 1; k < int'(DEPTH); k++) begin
                validQ[k] <= validQ[k-1];
            end
        end
        addrQ[0] <= bus.RegWriteAddr_wb;
        dataQ[0] <= bus.RegWriteData_wb;
        for (int k = 1; k < int'(DEPTH); k++) begin
            addrQ[k] <= addrQ[k-1];
            dataQ[k] <= dataQ[k-1];
        end
    end

    logic [DEPTH:0]              candValid;
    logic [(DEPTH+1)*ADDR_W-1:0] candAddr;
    logic [(DEPTH+1)*DATA_W-1:0] candData;

    // Reset suppresses every candidate, including the live write.
    always_comb begin
        candValid    = '0;
        candAddr     = '0;
        candData     = '0;
        candValid[0] = FWD_LIVE && liveWrite && !rst;
        candAddr[0 +: ADDR_W] = bus.RegWriteAddr_wb;
        candData[0 +: DATA_W] = bus.RegWriteData_wb;
        for (int k = 0; k < int'(DEPTH); k++) begin
            candValid[k+1]                 = validQ[k] && !rst;
            candAddr[(k+1)*ADDR_W +: ADDR_W] = addrQ[k];
            candData[(k+1)*DATA_W +: DATA_W] = dataQ[k];
        end
    end

    logic [NUM_RD*DATA_W-1:0] rdData;
    logic [NUM_RD-1:0]        fwdSel;
    logic [NUM_RD*4-1:0]      hitLvl;

    for (genvar i = 0; i < NUM_RD; i++) begin : gen_port
        bypass_match #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .DEPTH  (DEPTH)
        ) u_match (
            .rdAddr    (bus.RdAddr_id[i*ADDR_W +: ADDR_W]),
            .rfData    (bus.RfData_id[i*DATA_W +: DATA_W]),
            .candValid (candValid),
            .candAddr  (candAddr),
            .candData  (candData),
            .rdData    (rdData[i*DATA_W +: DATA_W]),
            .fwdSel    (fwdSel[i]),
            .hitLvl    (hitLvl[i*4 +: 4])
        );
    end

    assign bus.RdData_id   = rdData;
    assign bus.Fwd_sel     = fwdSel;
    assign bus.Fwd_hit_lvl = hitLvl;

endmodule

// File: tb/tb_wb_bypass_buffer.sv
// Directed bench: DUT A (2 ports, live forwarding) and DUT B (3 ports, buffered only).
module tb_wb_bypass_buffer;
    import pipeline_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    wb_bypass_buffer_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) busA ();
    wb_bypass_buffer_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(3)) busB ();

    wb_bypass_buffer #(
        .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .DEPTH(2), .FWD_LIVE(1'b1)
    ) dutA (
        .clk (clk),
        .rst (rst),
        .bus (busA.slave)
    );

    wb_bypass_buffer #(
        .DATA_W(32), .ADDR_W(5), .NUM_RD(3), .DEPTH(2), .FWD_LIVE(1'b0)
    ) dutB (
        .clk (clk),
        .rst (rst),
        .bus (busB.slave)
    );

    task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wbA(input logic we, input logic [4:0] a, input logic [31:0] d, input logic fl);
        busA.RegWrite_wb = we; busA.RegWriteAddr_wb = a; busA.RegWriteData_wb = d;
        busA.flush = fl;
    endtask

    task automatic wbB(input logic we, input logic [4:0] a, input logic [31:0] d);
        busB.RegWrite_wb = we; busB.RegWriteAddr_wb = a; busB.RegWriteData_wb = d;
        busB.flush = 1'b0;
    endtask

    task automatic rdA(input logic [4:0] a0, input logic [31:0] r0,
                       input logic [4:0] a1, input logic [31:0] r1);
        busA.RdAddr_id = {a1, a0};
        busA.RfData_id = {r1, r0};
    endtask

    task automatic expA(input string tag, input int p, input logic [31:0] d, input logic s,
                        input logic [3:0] l);
        checkVal({tag, ".data"}, busA.RdData_id[p*32 +: 32], d);
        checkVal({tag, ".sel"}, 32'(busA.Fwd_sel[p]), 32'(s));
        checkVal({tag, ".lvl"}, 32'(busA.Fwd_hit_lvl[p*4 +: 4]), 32'(l));
    endtask

    task automatic expB(input string tag, input int p, input logic [31:0] d, input logic s,
                        input logic [3:0] l);
        checkVal({tag, ".data"}, busB.RdData_id[p*32 +: 32], d);
        checkVal({tag, ".sel"}, 32'(busB.Fwd_sel[p]), 32'(s));
        checkVal({tag, ".lvl"}, 32'(busB.Fwd_hit_lvl[p*4 +: 4]), 32'(l));
    endtask

    initial begin
        wbB(1'b0, 5'd0, 32'h0);
        busB.RdAddr_id = '0;
        busB.RfData_id = '0;

        // Reset held with a live write present: no forwarding at all.
        rst = 1'b1;
        wbA(1'b1, 5'd9, 32'h99, 1'b0);
        rdA(5'd9, 32'h1234, 5'd0, 32'h5);
        #1;
        expA("rstLive.p0", 0, 32'h1234, 1'b0, HIT_NONE);
        expA("rstLive.p1", 1, 32'h5, 1'b0, HIT_NONE);
        step();
        wbA(1'b0, 5'd0, 32'h0, 1'b0);
        step();
        rst = 1'b0;
        rdA(5'd9, 32'h900, 5'd0, 32'h0);
        #1;
        expA("postRst", 0, 32'h900, 1'b0, HIT_NONE);

        // Live forward on port 0, miss on port 1.
        step();
        wbA(1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
        rdA(5'd5, 32'h0, 5'd6, 32'h66);
        #1;
        expA("live.p0", 0, 32'hDEADBEEF, 1'b1, 4'd0);
        expA("live.p1", 1, 32'h66, 1'b0, HIT_NONE);

        // Aging of r7; port 1 hits r5 in entry 0 in the same cycle.
        step();
        wbA(1'b1, 5'd7, 32'h11, 1'b0);
        rdA(5'd7, 32'h70, 5'd5, 32'h50);
        #1;
        expA("age0.p0", 0, 32'h11, 1'b1, 4'd0);
        expA("age0.p1", 1, 32'hDEADBEEF, 1'b1, 4'd1);
        step();
        wbA(1'b0, 5'd0, 32'h0, 1'b0);
        rdA(5'd7, 32'h70, 5'd0, 32'h0);
        #1;
        expA("age1", 0, 32'h11, 1'b1, 4'd1);
        step();
        expA("age2", 0, 32'h11, 1'b1, 4'd2);
        step();
        expA("age3", 0, 32'h70, 1'b0, HIT_NONE);

        // Same register written twice: newest wins.
        step();
        wbA(1'b1, 5'd3, 32'hA, 1'b0);
        rdA(5'd0, 32'h0, 5'd0, 32'h0);
        step();
        wbA(1'b1, 5'd3, 32'hB, 1'b0);
        rdA(5'd3, 32'h30, 5'd3, 32'h31);
        #1;
        expA("prioLive", 0, 32'hB, 1'b1, 4'd0);
        step();
        wbA(1'b0, 5'd0, 32'h0, 1'b0);
        #1;
        expA("prioE0.p0", 0, 32'hB, 1'b1, 4'd1);
        expA("prioE0.p1", 1, 32'hB, 1'b1, 4'd1);
        step();
        expA("prioE1", 0, 32'hB, 1'b1, 4'd2);

        // Register 0 is never forwarded.
        step();
        wbA(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0);
        rdA(5'd0, 32'h123, 5'd0, 32'h124);
        #1;
        expA("zero0", 0, 32'h123, 1'b0, HIT_NONE);
        step();
        wbA(1'b0, 5'd0, 32'h0, 1'b0);
        #1;
        expA("zero1", 1, 32'h124, 1'b0, HIT_NONE);

        // Flush empties the buffer.
        step();
        wbA(1'b1, 5'd9, 32'h55, 1'b0);
        rdA(5'd9, 32'h900, 5'd0, 32'h0);
        step();
        wbA(1'b0, 5'd0, 32'h0, 1'b1);
        #1;
        expA("flushHold", 0, 32'h55, 1'b1, 4'd1);
        step();
        wbA(1'b0, 5'd0, 32'h0, 1'b0);
        #1;
        expA("flushed", 0, 32'h900, 1'b0, HIT_NONE);

        // A live write coinciding with flush forwards live but is not captured.
        step();
        wbA(1'b1, 5'd10, 32'h10, 1'b1);
        rdA(5'd10, 32'hA00, 5'd0, 32'h0);
        #1;
        expA("flushLive", 0, 32'h10, 1'b1, 4'd0);
        step();
        wbA(1'b0, 5'd0, 32'h0, 1'b0);
        #1;
        expA("flushDrop", 0, 32'hA00, 1'b0, HIT_NONE);

        // Reset mid-operation with buffered r9 and a live r9 write.
        step();
        wbA(1'b1, 5'd9, 32'h55, 1'b0);
        rdA(5'd9, 32'h900, 5'd0, 32'h0);
        step();
        wbA(1'b1, 5'd9, 32'h66, 1'b0);
        rst = 1'b1;
        #1;
        expA("rstMid", 0, 32'h900, 1'b0, HIT_NONE);
        step();
        rst = 1'b0;
        wbA(1'b0, 5'd0, 32'h0, 1'b0);
        #1;
        expA("rstAfter", 0, 32'h900, 1'b0, HIT_NONE);

        // Buffered-only instance with three ports reading the same register.
        step();
        wbB(1'b1, 5'd4, 32'h77);
        busB.RdAddr_id = {5'd4, 5'd4, 5'd4};
        busB.RfData_id = {32'h42, 32'h41, 32'h40};
        #1;
        expB("noLive.p0", 0, 32'h40, 1'b0, HIT_NONE);
        expB("noLive.p1", 1, 32'h41, 1'b0, HIT_NONE);
        expB("noLive.p2", 2, 32'h42, 1'b0, HIT_NONE);
        step();
        wbB(1'b0, 5'd0, 32'h0);
        #1;
        expB("buf.p0", 0, 32'h77, 1'b1, 4'd1);
        expB("buf.p1", 1, 32'h77, 1'b1, 4'd1);
        expB("buf.p2", 2, 32'h77, 1'b1, 4'd1);
        step();
        expB("bufOld", 2, 32'h77, 1'b1, 4'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
